// File: rtl/reg_view_if.sv
// Display/CPU-side signal bundle for reg_view_server: display read port plus CPU register-file select/data.
interface reg_view_if #(
  parameter int DATA_W = 32,
  parameter int SEL_W  = 4
);
  logic [8:0]        addr;
  logic              finished_register;
  logic [DATA_W-1:0] register_value;
  logic [SEL_W-1:0]  cpu_reg_sel;
  logic [DATA_W-1:0] cpu_reg_data;
  logic              snapshot_valid;
  logic              capture_busy;

  modport master (
    output addr, finished_register, cpu_reg_data,
    input  register_value, cpu_reg_sel, snapshot_valid, capture_busy
  );

  modport slave (
    input  addr, finished_register, cpu_reg_data,
    output register_value, cpu_reg_sel, snapshot_valid, capture_busy
  );
endinterface

// File: rtl/reg_view_server.sv
// Double-buffered CPU register snapshot served to the VGA register viewer.
// Optional REGVIEW_FRAME_WORD_EN exposes frame_count and snapshot_valid just above the register range.
module reg_view_server #(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 32,
  parameter int SEL_W    = 4
) (
  input logic       CLOCK_50,
  input logic       reset,
  reg_view_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REGS);

  typedef enum logic {CAPTURE, SWAP_WAIT} state_t;

  state_t            state, state_next;
  logic [IDX_W-1:0]  idx;
  logic              idx_last;
  logic              front, front_next;
  logic              valid, valid_next;
  logic              fin_q, rise, pending, swap;
  logic              capture_busy;
  logic [SEL_W-1:0]  cpu_reg_sel;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] rd_data_p0, rd_data_p1;
  logic [DATA_W-1:0] bank0 [NUM_REGS];
  logic [DATA_W-1:0] bank1 [NUM_REGS];
`ifdef REGVIEW_FRAME_WORD_EN
  logic [31:0]       frame_count, frame_next;
`endif

  assign idx_last   = (idx == IDX_W'(NUM_REGS - 1));
  assign rise       = bus.finished_register & ~fin_q;
  assign front_next = front ^ swap;
  assign valid_next = valid | swap;
  assign rd_idx     = bus.addr[IDX_W-1:0];
`ifdef REGVIEW_FRAME_WORD_EN
  assign frame_next = frame_count + (swap ? 32'd1 : 32'd0);
`endif

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= CAPTURE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    swap         = 1'b0;
    capture_busy = 1'b0;
    cpu_reg_sel  = '0;
    unique case (state)
      CAPTURE: begin
        capture_busy = 1'b1;
        cpu_reg_sel  = SEL_W'(idx);
        if (idx_last) state_next = SWAP_WAIT;
      end
      SWAP_WAIT: begin
        if (pending) begin
          swap       = 1'b1;
          state_next = CAPTURE;
        end
      end
      default: state_next = CAPTURE;
    endcase
  end

  // Read stage p0: front selection already reflects a swap on this edge
  always_comb begin
    rd_data_p0 = '0;
    if (bus.addr < 9'(NUM_REGS)) begin
      rd_data_p0 = front_next ? bank1[rd_idx] : bank0[rd_idx];
    end
`ifdef REGVIEW_FRAME_WORD_EN
    else if (bus.addr == 9'(NUM_REGS)) begin
      rd_data_p0 = DATA_W'(frame_next);
    end else if (bus.addr == 9'(NUM_REGS + 1)) begin
      rd_data_p0 = DATA_W'(valid_next);
    end
`endif
  end

  // Stage p1: capture write into the back bank, pending tracking, registered read data
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      idx        <= '0;
      front      <= 1'b0;
      valid      <= 1'b0;
      fin_q      <= 1'b0;
      pending    <= 1'b0;
      rd_data_p1 <= '0;
`ifdef REGVIEW_FRAME_WORD_EN
      frame_count <= '0;
`endif
      for (int i = 0; i < NUM_REGS; i++) begin
        bank0[i] <= '0;
        bank1[i] <= '0;
      end
    end else begin
      fin_q      <= bus.finished_register;
      pending    <= swap ? rise : (pending | rise);
      front      <= front_next;
      valid      <= valid_next;
      rd_data_p1 <= rd_data_p0;
      idx        <= (capture_busy && !idx_last) ? idx + 1'b1 : '0;
`ifdef REGVIEW_FRAME_WORD_EN
      frame_count <= frame_next;
`endif
      if (capture_busy) begin
        if (front) bank0[idx] <= bus.cpu_reg_data;
        else       bank1[idx] <= bus.cpu_reg_data;
      end
    end
  end

  assign bus.register_value = rd_data_p1;
  assign bus.cpu_reg_sel    = cpu_reg_sel;
  assign bus.snapshot_valid = valid;
  assign bus.capture_busy   = capture_busy;
endmodule
